// File: rtl/fp_conv_pkg.sv
// Shared types and constants for the float-to-float conversion paths.
// Holds rounding modes, flag indices, FP classes and the stage-1 to stage-2 bundle.
package fp_conv_pkg;

  localparam int unsigned ExpInW  = 11;
  localparam int unsigned SigInW  = 53;
  localparam int unsigned ExpOutW = 8;
  localparam int unsigned SigOutW = 24;
  localparam int unsigned ExpW    = ExpInW + 1;

  localparam int BiasDiff = (2 ** (ExpInW - 1) - 1) - (2 ** (ExpOutW - 1) - 1);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ClsZero,
    ClsSub,
    ClsNorm,
    ClsInf,
    ClsQnan,
    ClsSnan
  } fp_class_e;

  // exp is the biased FP32 exponent, 0 when the value sits in the subnormal range.
  // near_min/ub_* let stage 2 detect tininess as if the exponent range were unbounded.
  typedef struct packed {
    logic              sign;
    fp_class_e         cls;
    logic [ExpW-1:0]   exp;
    logic [SigOutW-1:0] sig;
    logic              g;
    logic              r;
    logic              s;
    logic              near_min;
    logic              ub_g;
    logic              ub_rs;
    logic [2:0]        rm;
  } s1_bundle_t;

  // Reserved encodings fall through to round-to-nearest-even.
  function automatic logic round_up(input logic [2:0] rm, input logic sign, input logic lsb,
                                    input logic g, input logic r, input logic s);
    logic any;
    any = g | r | s;
    case (rm)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return sign & any;
      RM_RUP:  return ~sign & any;
      RM_RMM:  return g;
      default: return g & (r | s | lsb);
    endcase
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational rounding, overflow/underflow selection and FP32 packing.
// Shared with the integer-to-float path, which only presents zero/normal classes.
module fp_round_pack
  import fp_conv_pkg::*;
(
  input  logic               sign_i,
  input  logic [2:0]         cls_i,
  input  logic [ExpW-1:0]    exp_i,
  input  logic [SigOutW-1:0] sig_i,
  input  logic               g_i,
  input  logic               r_i,
  input  logic               s_i,
  input  logic               near_min_i,
  input  logic               ub_g_i,
  input  logic               ub_rs_i,
  input  logic [2:0]         rm_i,
  output logic [31:0]        res_o,
  output logic [4:0]         flags_o
);

  logic               inc;
  logic [SigOutW:0]   sig_rnd;
  logic [ExpW-1:0]    exp_rnd;
  logic [SigOutW-2:0] frac;
  logic               inexact;
  logic               tiny;
  logic               ovf;
  logic               to_inf;

  always_comb begin
    inc     = round_up(rm_i, sign_i, sig_i[0], g_i, r_i, s_i);
    sig_rnd = {1'b0, sig_i} + (SigOutW + 1)'(inc);
    // A carry past the hidden bit, or a subnormal reaching the hidden bit, bumps the exponent.
    exp_rnd = exp_i + ExpW'(sig_rnd[SigOutW])
            + ExpW'((exp_i == '0) & sig_rnd[SigOutW-1]);
    frac    = sig_rnd[SigOutW] ? sig_rnd[SigOutW-1:1] : sig_rnd[SigOutW-2:0];
    inexact = g_i | r_i | s_i;
    tiny    = (exp_i == '0) & ~(near_min_i & round_up(rm_i, sign_i, 1'b1, ub_g_i, ub_rs_i, 1'b0));
    ovf     = exp_rnd >= ExpW'(2 ** ExpOutW - 1);

    case (rm_i)
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = sign_i;
      RM_RUP:  to_inf = ~sign_i;
      default: to_inf = 1'b1;
    endcase

    res_o   = '0;
    flags_o = '0;
    case (fp_class_e'(cls_i))
      ClsZero: res_o = {sign_i, 31'b0};
      ClsInf:  res_o = {sign_i, 8'hFF, 23'b0};
      ClsQnan: res_o = FP32_QNAN;
      ClsSnan: begin
        res_o            = FP32_QNAN;
        flags_o[FLAG_NV] = 1'b1;
      end
      default: begin
        if (ovf) begin
          res_o            = to_inf ? {sign_i, 8'hFF, 23'b0} : {sign_i, 8'hFE, 23'h7FFFFF};
          flags_o[FLAG_OF] = 1'b1;
          flags_o[FLAG_NX] = 1'b1;
        end else begin
          res_o            = {sign_i, exp_rnd[ExpOutW-1:0], frac};
          flags_o[FLAG_UF] = tiny & inexact;
          flags_o[FLAG_NX] = inexact;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_narrow_conv.sv
// Two-stage FP64-to-FP32 narrowing converter (FCVT.S.D) with valid/ready on both sides.
// Stage 1 unpacks and aligns into the FP32 grid; stage 2 rounds and packs.
module fp_narrow_conv
  import fp_conv_pkg::*;
#(
  parameter int unsigned EXP_IN  = ExpInW,
  parameter int unsigned SIG_IN  = SigInW,
  parameter int unsigned EXP_OUT = ExpOutW,
  parameter int unsigned SIG_OUT = SigOutW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_IN+SIG_IN-1:0]   in_a,
  input  logic [2:0]                 in_rm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_OUT+SIG_OUT-1:0] out_res,
  output logic [4:0]                 out_flags
);

  localparam int unsigned ManW = SigInW - 1;
  localparam int unsigned EW   = ExpInW + 2;
  localparam int unsigned PadW = SigOutW + 2;
  localparam int unsigned ExtW = SigInW + PadW;

  logic [ExpInW-1:0] exp_f;
  logic [ManW-1:0]   man;
  logic [SigInW-1:0] sig_in;
  logic [EW-1:0]     e_rb;
  logic [EW-1:0]     sh_full;
  logic              e_le0;
  logic [4:0]        sh;
  logic [ExtW-1:0]   ext;
  s1_bundle_t        s1_new, s1_d, s1_q;

  logic        s1_valid_d, s1_valid_q;
  logic        s2_valid_d, s2_valid_q;
  logic        s1_adv, s2_adv;
  logic [31:0] rp_res, out_res_d, out_res_q;
  logic [4:0]  rp_flags, out_flags_d, out_flags_q;

  always_comb begin
    exp_f   = in_a[ManW +: ExpInW];
    man     = in_a[ManW-1:0];
    sig_in  = {exp_f != '0, man};
    e_rb    = {2'b00, exp_f} - EW'(BiasDiff);
    e_le0   = e_rb[EW-1] | (e_rb == '0);
    sh_full = EW'(1) - e_rb;
    sh      = '0;
    if (e_le0) begin
      sh = (sh_full > EW'(PadW)) ? 5'(PadW) : sh_full[4:0];
    end
    // The zero pad is as wide as the largest shift, so no set bit ever falls off the end.
    ext = {sig_in, {PadW{1'b0}}} >> sh;

    s1_new          = '0;
    s1_new.sign     = in_a[ExpInW+ManW];
    s1_new.rm       = in_rm;
    s1_new.exp      = e_le0 ? '0 : e_rb[ExpW-1:0];
    s1_new.sig      = ext[ExtW-1 -: SigOutW];
    s1_new.g        = ext[ExtW-SigOutW-1];
    s1_new.r        = ext[ExtW-SigOutW-2];
    s1_new.s        = |ext[ExtW-SigOutW-3:0];
    s1_new.near_min = (e_rb == '0) & (&sig_in[SigInW-1 -: SigOutW]);
    s1_new.ub_g     = sig_in[SigInW-SigOutW-1];
    s1_new.ub_rs    = |sig_in[SigInW-SigOutW-2:0];
    s1_new.cls      = ClsNorm;

    if (exp_f == '1) begin
      if (man == '0)          s1_new.cls = ClsInf;
      else if (man[ManW-1])   s1_new.cls = ClsQnan;
      else                    s1_new.cls = ClsSnan;
    end else if (exp_f == '0) begin
      if (man == '0) begin
        s1_new.cls = ClsZero;
      end else begin
        // FP64 subnormals are far below the FP32 range: only a sticky bit survives.
        s1_new.cls      = ClsSub;
        s1_new.exp      = '0;
        s1_new.sig      = '0;
        s1_new.g        = 1'b0;
        s1_new.r        = 1'b0;
        s1_new.s        = 1'b1;
        s1_new.near_min = 1'b0;
      end
    end
  end

  always_comb begin
    s2_adv      = ~s2_valid_q | out_ready;
    s1_adv      = ~s1_valid_q | s2_adv;
    s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
    s1_d        = (in_valid & s1_adv) ? s1_new : s1_q;
    s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
    out_res_d   = (s2_adv & s1_valid_q) ? rp_res : out_res_q;
    out_flags_d = (s2_adv & s1_valid_q) ? rp_flags : out_flags_q;
  end

  fp_round_pack u_round_pack (
    .sign_i     (s1_q.sign),
    .cls_i      (s1_q.cls),
    .exp_i      (s1_q.exp),
    .sig_i      (s1_q.sig),
    .g_i        (s1_q.g),
    .r_i        (s1_q.r),
    .s_i        (s1_q.s),
    .near_min_i (s1_q.near_min),
    .ub_g_i     (s1_q.ub_g),
    .ub_rs_i    (s1_q.ub_rs),
    .rm_i       (s1_q.rm),
    .res_o      (rp_res),
    .flags_o    (rp_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_res_q   <= '0;
      out_flags_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_res_q   <= out_res_d;
      out_flags_q <= out_flags_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_res   = out_res_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_narrow_conv.sv
// Directed bench for fp_narrow_conv: a vector table for the arithmetic, then
// hand-written backpressure and mid-flight reset sequences.
module tb_fp_narrow_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_flags;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic [63:0] a;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  flags;
  } vec_t;

  localparam int NumVec = 28;
  vec_t vecs[NumVec];

  fp_narrow_conv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_rm     (in_rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{64'h3FF0000000000000, 3'd0, 32'h3F800000, 5'h00};
    vecs[1]  = '{64'h3FB999999999999A, 3'd0, 32'h3DCCCCCD, 5'h01};
    vecs[2]  = '{64'h3FB999999999999A, 3'd1, 32'h3DCCCCCC, 5'h01};
    vecs[3]  = '{64'h7E37E43C8800759C, 3'd0, 32'h7F800000, 5'h05};
    vecs[4]  = '{64'h7E37E43C8800759C, 3'd1, 32'h7F7FFFFF, 5'h05};
    vecs[5]  = '{64'hFE37E43C8800759C, 3'd3, 32'hFF7FFFFF, 5'h05};
    vecs[6]  = '{64'hFE37E43C8800759C, 3'd2, 32'hFF800000, 5'h05};
    vecs[7]  = '{64'h7E37E43C8800759C, 3'd2, 32'h7F7FFFFF, 5'h05};
    vecs[8]  = '{64'h36A0000000000000, 3'd0, 32'h00000001, 5'h00};
    vecs[9]  = '{64'h3690000000000000, 3'd0, 32'h00000000, 5'h03};
    vecs[10] = '{64'h3690000000000000, 3'd3, 32'h00000001, 5'h03};
    vecs[11] = '{64'h3690000000000000, 3'd4, 32'h00000001, 5'h03};
    vecs[12] = '{64'h7FF0000000000001, 3'd0, 32'h7FC00000, 5'h10};
    vecs[13] = '{64'h7FF8000000000000, 3'd0, 32'h7FC00000, 5'h00};
    vecs[14] = '{64'hFFF0000000000000, 3'd0, 32'hFF800000, 5'h00};
    vecs[15] = '{64'h8000000000000000, 3'd0, 32'h80000000, 5'h00};
    vecs[16] = '{64'h0000000000000001, 3'd0, 32'h00000000, 5'h03};
    vecs[17] = '{64'h0000000000000001, 3'd3, 32'h00000001, 5'h03};
    vecs[18] = '{64'h8000000000000001, 3'd2, 32'h80000001, 5'h03};
    vecs[19] = '{64'h47EFFFFFE0000000, 3'd0, 32'h7F7FFFFF, 5'h00};
    vecs[20] = '{64'h47EFFFFFF0000000, 3'd0, 32'h7F800000, 5'h05};
    vecs[21] = '{64'h3810000000000000, 3'd0, 32'h00800000, 5'h00};
    vecs[22] = '{64'h380FFFFFFFFFFFFF, 3'd0, 32'h00800000, 5'h01};
    vecs[23] = '{64'h380FFFFFE0000000, 3'd0, 32'h00800000, 5'h03};
    vecs[24] = '{64'h3FF0000010000000, 3'd0, 32'h3F800000, 5'h01};
    vecs[25] = '{64'h3FF0000010000000, 3'd4, 32'h3F800001, 5'h01};
    vecs[26] = '{64'h3FF0000010000000, 3'd5, 32'h3F800000, 5'h01};
    vecs[27] = '{64'hBFB999999999999A, 3'd2, 32'hBDCCCCCD, 5'h01};

    in_valid  = 1'b0;
    in_a      = '0;
    in_rm     = '0;
    out_ready = 1'b1;
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_res", out_res, 0);
    check("reset_out_flags", out_flags, 0);
    rst_n = 1'b1;
    step();
    check("post_reset_in_ready", in_ready, 1);

    for (int i = 0; i < NumVec; i++) begin
      in_valid = 1'b1;
      in_a     = vecs[i].a;
      in_rm    = vecs[i].rm;
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_lat1_valid", i), out_valid, 0);
      step();
      check($sformatf("v%0d_lat2_valid", i), out_valid, 1);
      check($sformatf("v%0d_res", i), out_res, vecs[i].res);
      check($sformatf("v%0d_flags", i), out_flags, vecs[i].flags);
    end
    step();
    check("idle_out_valid", out_valid, 0);

    // Backpressure: 1.0, 2.0, 3.0 offered while the consumer stalls.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_rm     = 3'd0;
    in_a      = 64'h3FF0000000000000;
    #1;
    check("bp_ready_a", in_ready, 1);
    step();
    in_a = 64'h4000000000000000;
    check("bp_ready_b", in_ready, 1);
    step();
    in_a = 64'h4008000000000000;
    check("bp_ready_c_blocked", in_ready, 0);
    check("bp_valid_a", out_valid, 1);
    check("bp_res_a", out_res, 32'h3F800000);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_hold%0d_ready", k), in_ready, 0);
      check($sformatf("bp_hold%0d_valid", k), out_valid, 1);
      check($sformatf("bp_hold%0d_res", k), out_res, 32'h3F800000);
      check($sformatf("bp_hold%0d_flags", k), out_flags, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_valid_b", out_valid, 1);
    check("bp_res_b", out_res, 32'h40000000);
    step();
    check("bp_valid_c", out_valid, 1);
    check("bp_res_c", out_res, 32'h40400000);
    step();
    check("bp_drained", out_valid, 0);

    // Reset with two items in flight.
    in_valid = 1'b1;
    in_a     = 64'h3FF0000000000000;
    step();
    in_a = 64'h4000000000000000;
    step();
    in_valid = 1'b0;
    check("rst_inflight_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_res", out_res, 0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rst_flush%0d_valid", k), out_valid, 0);
      check($sformatf("rst_flush%0d_ready", k), in_ready, 1);
    end
    in_valid = 1'b1;
    in_a     = 64'h4008000000000000;
    step();
    in_valid = 1'b0;
    step();
    check("rst_after_valid", out_valid, 1);
    check("rst_after_res", out_res, 32'h40400000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
